// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing an RV32I multicycle datapath
// (lw, sw, R-type, I-type ALU, beq, jal). Counts retired instructions and
// halts in TRAP on unsupported opcodes.
// Optional build macro MEM_HANDSHAKE_EN adds a mem_ready input that stalls
// FETCH, MEMREAD and MEMWRITE until memory is ready.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read instr at pc, latch IR/old_pc, pc <= pc + 4
// DECODE   | decode opcode, precompute old_pc + imm into alu_out
// MEMADR   | address = reg A + imm
// MEMREAD  | read data memory at alu_out
// MEMWB    | write loaded data to register file
// MEMWRITE | write reg B to data memory at alu_out
// EXECR    | reg A op reg B
// EXECI    | reg A op imm
// ALUWB    | write alu_out to register file
// JAL      | pc <= target (alu_out), compute link old_pc + 4
// BEQ      | compare via subtract, branch to alu_out when zero
// TRAP     | unsupported opcode, halted until reset
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
`ifdef MEM_HANDSHAKE_EN
    input  logic             mem_ready,
`endif
    output logic             pc_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             w_en,
    output logic             w_en3,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       imm_src,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t     state;
    state_t     state_next;
    logic       mem_rdy;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       w_en_raw;
    logic       w_en3_raw;
    logic       retire;
    logic [2:0] funct_alu;

`ifdef MEM_HANDSHAKE_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // State register; reset restarts at FETCH.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    // ALU operation for R/I execute; only R-type (op[5]=1) can select sub.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_alu = ALU_SLT;
            3'b110:  funct_alu = ALU_OR;
            3'b111:  funct_alu = ALU_AND;
            default: funct_alu = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode directly, independent of state.
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Next-state and per-state outputs; enables pulse only when memory is ready.
    always_comb begin
        state_next   = state;
        pc_update    = 1'b0;
        branch       = 1'b0;
        adr_src      = 1'b0;
        ir_write_raw = 1'b0;
        w_en_raw     = 1'b0;
        w_en3_raw    = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_ctrl     = ALU_ADD;
        halted       = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_rdy) begin
                    ir_write_raw = 1'b1;
                    pc_update    = 1'b1;
                    state_next   = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_I:         state_next = EXECI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                // Only lw/sw reach here; op[5] separates store from load.
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_rdy) state_next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                w_en3_raw  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                if (mem_rdy) begin
                    w_en_raw   = 1'b1;
                    state_next = FETCH;
                end
            end
            EXECR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_ctrl   = funct_alu;
                state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_ctrl   = funct_alu;
                state_next = ALUWB;
            end
            ALUWB: begin
                w_en3_raw  = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                state_next = ALUWB;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_ctrl   = ALU_SUB;
                branch     = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                halted = 1'b1;
            end
            default: begin
                halted     = 1'b1;
                state_next = TRAP;
            end
        endcase
    end

    // Reset overrides every enable so an aborted instruction writes nothing.
    always_comb begin
        pc_write = ~rst & (pc_update | (branch & zero));
        ir_write = ~rst & ir_write_raw;
        w_en     = ~rst & w_en_raw;
        w_en3    = ~rst & w_en3_raw;
        retire   = ~rst & (state_next == FETCH) &
                   ((state == MEMWB) | (state == MEMWRITE) |
                    (state == ALUWB) | (state == BEQ));
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst)         instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed vector table, hand-written
// reset/trap/wrap sequences, and randomized instructions checked against an
// instruction-level model (expected outputs per cycle of each instruction).
module tb_multicycle_ctrl;
    localparam int CNT_W = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             pc_write, adr_src, ir_write, w_en, w_en3, halted;
    logic [1:0]       result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]       alu_ctrl;
    logic [CNT_W-1:0] instret;
`ifdef MEM_HANDSHAKE_EN
    logic             mem_ready = 1'b1;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero),
`ifdef MEM_HANDSHAKE_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .w_en(w_en), .w_en3(w_en3), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .imm_src(imm_src), .halted(halted), .instret(instret)
    );

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       ir_write;
        logic       w_en;
        logic       w_en3;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] imm_src;
        logic       halted;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [2:0] exec_alu;
    } vec_t;

    outs_t got;
    assign got = {pc_write, adr_src, ir_write, w_en, w_en3, result_src,
                  alu_src_a, alu_src_b, alu_ctrl, imm_src, halted};

    int checks = 0;
    int errors = 0;
    int retired = 0;

    function automatic int latency(input logic [6:0] o);
        case (o)
            OP_LW:                       return 5;
            OP_SW, OP_R, OP_I, OP_JAL:   return 4;
            OP_BEQ:                      return 3;
            default:                     return 0;
        endcase
    endfunction

    function automatic logic [2:0] alu_for(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
        case (f3)
            3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs at a given cycle (step) of executing one instruction.
    function automatic outs_t expect_out(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7, input logic z, input int step);
        outs_t e;
        e = '0;
        e.imm_src = (o == OP_SW) ? 2'b01 : (o == OP_BEQ) ? 2'b10 :
                    (o == OP_JAL) ? 2'b11 : 2'b00;
        if (step == 0) begin
            e.pc_write = 1'b1; e.ir_write = 1'b1;
            e.alu_src_b = 2'b10; e.result_src = 2'b10;
        end else if (step == 1) begin
            e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
        end else begin
            case (o)
                OP_LW, OP_SW: begin
                    if (step == 2) begin
                        e.alu_src_a = 2'b10; e.alu_src_b = 2'b01;
                    end else if (step == 3) begin
                        e.adr_src = 1'b1;
                        e.w_en = (o == OP_SW);
                    end else begin
                        e.result_src = 2'b01; e.w_en3 = 1'b1;
                    end
                end
                OP_R, OP_I: begin
                    if (step == 2) begin
                        e.alu_src_a = 2'b10;
                        e.alu_src_b = (o == OP_I) ? 2'b01 : 2'b00;
                        e.alu_ctrl = alu_for(o, f3, f7);
                    end else e.w_en3 = 1'b1;
                end
                OP_JAL: begin
                    if (step == 2) begin
                        e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
                    end else e.w_en3 = 1'b1;
                end
                OP_BEQ: begin
                    e.alu_src_a = 2'b10; e.alu_ctrl = 3'b001; e.pc_write = z;
                end
                default: e.halted = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic check_out(input string name, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s outputs got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name);
        logic [CNT_W-1:0] exp;
        exp = CNT_W'(retired);
        checks++;
        if (instret !== exp) begin
            errors++;
            $display("FAIL %s instret got=%0d expected=%0d", name, instret, exp);
        end
    endtask

    task automatic check_rst_enables(input string name);
        checks++;
        if ({pc_write, ir_write, w_en, w_en3} !== 4'b0000) begin
            errors++;
            $display("FAIL %s enables under reset got=%b expected=0000", name,
                     {pc_write, ir_write, w_en, w_en3});
        end
    endtask

    // Runs one instruction from FETCH; entered and left just after a negedge.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int lat,
                             output logic [2:0] alu_seen);
        alu_seen = 3'bxxx;
        for (int s = 0; s < lat; s++) begin
            op = o; funct3 = f3; funct7b5 = f7; zero = z;
            #1;
            check_out($sformatf("%s step%0d", name, s), expect_out(o, f3, f7, z, s));
            if (s == 0) check_cnt($sformatf("%s fetch", name));
            if (s == 2) alu_seen = alu_ctrl;
            @(negedge clk);
        end
        retired++;
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        #1;
        check_rst_enables(name);
        @(negedge clk);
        rst = 1'b0;
        retired = 0;
    endtask

    vec_t       vecs[12];
    logic [2:0] alu_seen;
    logic [6:0] rop;
    logic [6:0] ops[6];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_LW,  3'b010, 1'b0, 1'b0, 5, 3'b000};
        vecs[1]  = '{OP_SW,  3'b010, 1'b1, 1'b0, 4, 3'b000};
        vecs[2]  = '{OP_R,   3'b000, 1'b1, 1'b0, 4, 3'b001};
        vecs[3]  = '{OP_R,   3'b000, 1'b0, 1'b0, 4, 3'b000};
        vecs[4]  = '{OP_I,   3'b000, 1'b1, 1'b0, 4, 3'b000};
        vecs[5]  = '{OP_R,   3'b010, 1'b0, 1'b0, 4, 3'b101};
        vecs[6]  = '{OP_R,   3'b110, 1'b1, 1'b0, 4, 3'b011};
        vecs[7]  = '{OP_I,   3'b111, 1'b0, 1'b0, 4, 3'b010};
        vecs[8]  = '{OP_R,   3'b100, 1'b1, 1'b0, 4, 3'b000};
        vecs[9]  = '{OP_BEQ, 3'b000, 1'b0, 1'b1, 3, 3'b001};
        vecs[10] = '{OP_BEQ, 3'b000, 1'b0, 1'b0, 3, 3'b001};
        vecs[11] = '{OP_JAL, 3'b000, 1'b0, 1'b0, 4, 3'b000};
        ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

        rst = 1'b1; op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        #1;
        check_rst_enables("reset_c1");
        @(negedge clk);
        #1;
        check_rst_enables("reset_c2");
        rst = 1'b0;

`ifdef MEM_HANDSHAKE_EN
        // FETCH stalls without memory ready: no ir_write/pc_write pulses.
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            outs_t e;
            #1;
            e = expect_out(OP_LW, 3'b010, 1'b0, 1'b0, 0);
            e.pc_write = 1'b0; e.ir_write = 1'b0;
            check_out($sformatf("stall_fetch c%0d", c), e);
            check_cnt("stall_fetch");
            @(negedge clk);
        end
        mem_ready = 1'b1;
`endif

        for (int i = 0; i < 12; i++) begin
            run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].f7,
                      vecs[i].z, vecs[i].lat, alu_seen);
            checks++;
            if (alu_seen !== vecs[i].exec_alu) begin
                errors++;
                $display("FAIL vec%0d exec alu_ctrl got=%b expected=%b", i, alu_seen,
                         vecs[i].exec_alu);
            end
        end

        // Unsupported opcode: TRAP absorbs and instret freezes.
        op = OP_BAD; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        for (int s = 0; s < 12; s++) begin
            #1;
            check_out($sformatf("trap step%0d", s), expect_out(OP_BAD, 3'b000, 1'b0, 1'b0, s));
            check_cnt("trap");
            @(negedge clk);
        end
        do_reset("trap_reset");

        // Reset during MEMWB of a lw: no write enable, no retire.
        op = OP_LW; funct3 = 3'b010;
        for (int s = 0; s < 4; s++) begin
            #1;
            check_out($sformatf("abort step%0d", s), expect_out(OP_LW, 3'b010, 1'b0, 1'b0, s));
            @(negedge clk);
        end
        do_reset("abort_memwb");

        for (int n = 0; n < 60; n++) begin
            logic [2:0] f3r;
            logic       f7r, zr;
            rop = ops[$urandom_range(0, 5)];
            f3r = 3'($urandom_range(0, 7));
            f7r = 1'($urandom_range(0, 1));
            zr  = 1'($urandom_range(0, 1));
            run_instr($sformatf("rand%0d", n), rop, f3r, f7r, zr, latency(rop), alu_seen);
        end

        // Counter wrap: 16 retirements from zero bring instret back to 0.
        do_reset("wrap_reset");
        for (int n = 0; n < 16; n++)
            run_instr($sformatf("wrap%0d", n), OP_BEQ, 3'b000, 1'b0, 1'b0, 3, alu_seen);
        #1;
        checks++;
        if (instret !== '0) begin
            errors++;
            $display("FAIL wrap instret got=%0d expected=0", instret);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
